fft_sequencer: RTL and testbench

FFT_SEQUENCER -- requirements
Module: fft_sequencer

---
 rtl/fft_sequencer.sv | 173 +++++++++++++++++
 tb/tb_fft_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sequencer.sv
// rtl/fft_sequencer.sv - frame sequencer between a real sample stream and an FFT core
//
// Collects N_POINTS real samples into the FFT core's load port, pulses fft_start,
// waits for the core, then re-registers the output bins onto result_*.
// Optional build macro: FFT_SEQ_HALF_SPECTRUM_EN - present only bins 0..N_POINTS/2-1.
//
// Ports:
//   clk, reset                    single clock, synchronous active-high reset
//   enable                        run frames back to back while high
//   sample_valid, sample_data     real input samples (16-bit signed)
//   fft_load, fft_load_address,   load strobe/address/data to the core, data = {re, im}
//   fft_data_in
//   fft_start                     one-cycle start pulse to the core
//   fft_done, fft_data_out        one output bin per fft_done cycle from the core
//   result_valid, result_idx,     registered bin stream
//   result_data
//   frame_done                    one-cycle pulse the cycle after the last presented bin
//   overrun, timeout              sticky error flags, cleared only by reset
//   busy                          state is not IDLE
`timescale 1ns/1ps

module fft_sequencer #(
  parameter int N_POINTS       = 512,
  parameter int TIMEOUT_CYCLES = 20000,
  localparam int AW            = $clog2(N_POINTS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          sample_valid,
  input  logic [15:0]   sample_data,
  output logic          fft_load,
  output logic [AW-1:0] fft_load_address,
  output logic [31:0]   fft_data_in,
  output logic          fft_start,
  input  logic          fft_done,
  input  logic [31:0]   fft_data_out,
  output logic          result_valid,
  output logic [AW-1:0] result_idx,
  output logic [31:0]   result_data,
  output logic          frame_done,
  output logic          overrun,
  output logic          timeout,
  output logic          busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef FFT_SEQ_HALF_SPECTRUM_EN
  localparam int OUT_BINS = N_POINTS / 2;
`else
  localparam int OUT_BINS = N_POINTS;
`endif

  localparam logic [AW-1:0] LAST_IDX = AW'(N_POINTS - 1);
  localparam logic [AW-1:0] LAST_OUT = AW'(OUT_BINS - 1);
  localparam logic [TW-1:0] WAIT_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    READ  = 3'd4
  } state_t;

  state_t        state;
  logic [AW-1:0] load_cnt;
  logic [AW-1:0] bin_cnt;
  logic [TW-1:0] wait_cnt;
  // Set when the last presented bin is registered; frame_done follows one cycle later.
  logic          last_seen;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      load_cnt         <= '0;
      bin_cnt          <= '0;
      wait_cnt         <= '0;
      last_seen        <= 1'b0;
      fft_load         <= 1'b0;
      fft_load_address <= '0;
      fft_data_in      <= '0;
      fft_start        <= 1'b0;
      result_valid     <= 1'b0;
      result_idx       <= '0;
      result_data      <= '0;
      frame_done       <= 1'b0;
      overrun          <= 1'b0;
      timeout          <= 1'b0;
    end else begin
      fft_load     <= 1'b0;
      fft_start    <= 1'b0;
      result_valid <= 1'b0;
      frame_done   <= last_seen;
      last_seen    <= 1'b0;

      // Samples are only accepted while loading; anything else is lost.
      if (sample_valid && state != LOAD) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            load_cnt <= '0;
            state    <= LOAD;
          end
        end

        LOAD: begin
          if (sample_valid) begin
            fft_load         <= 1'b1;
            fft_load_address <= load_cnt;
            fft_data_in      <= {sample_data, 16'h0000};
            load_cnt         <= load_cnt + 1'b1;
            if (load_cnt == LAST_IDX) begin
              state <= START;
            end
          end
        end

        // The last fft_load is being presented this cycle, so the start pulse
        // is registered here and appears one cycle later, never overlapping it.
        START: begin
          fft_start <= 1'b1;
          wait_cnt  <= '0;
          state     <= WAIT;
        end

        WAIT: begin
          if (fft_done) begin
            // The cycle that ends WAIT already carries bin 0.
            result_valid <= 1'b1;
            result_idx   <= '0;
            result_data  <= fft_data_out;
            bin_cnt      <= AW'(1);
            state        <= READ;
          end else if (wait_cnt == WAIT_MAX) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        READ: begin
          if (fft_done) begin
            if (bin_cnt <= LAST_OUT) begin
              result_valid <= 1'b1;
              result_idx   <= bin_cnt;
              result_data  <= fft_data_out;
            end
            if (bin_cnt == LAST_OUT) begin
              last_seen <= 1'b1;
            end
            bin_cnt <= bin_cnt + 1'b1;
            // Bins beyond the presented range are still consumed before leaving.
            if (bin_cnt == LAST_IDX) begin
              load_cnt <= '0;
              state    <= enable ? LOAD : IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_sequencer.sv
// tb/tb_fft_sequencer.sv - randomized self-checking bench for fft_sequencer
`timescale 1ns/1ps

module tb_fft_sequencer;

  localparam int N   = 512;
  localparam int TMO = 20000;
`ifdef FFT_SEQ_HALF_SPECTRUM_EN
  localparam int OUT_BINS = N / 2;
`else
  localparam int OUT_BINS = N;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        fft_load;
  logic [8:0]  fft_load_address;
  logic [31:0] fft_data_in;
  logic        fft_start;
  logic        fft_done;
  logic [31:0] fft_data_out;
  logic        result_valid;
  logic [8:0]  result_idx;
  logic [31:0] result_data;
  logic        frame_done;
  logic        overrun;
  logic        timeout;
  logic        busy;

  always #5 clk = ~clk;

  fft_sequencer #(.N_POINTS(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .fft_load(fft_load), .fft_load_address(fft_load_address), .fft_data_in(fft_data_in),
    .fft_start(fft_start), .fft_done(fft_done), .fft_data_out(fft_data_out),
    .result_valid(result_valid), .result_idx(result_idx), .result_data(result_data),
    .frame_done(frame_done), .overrun(overrun), .timeout(timeout), .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: frame phase plus sample/bin counts, advanced once per clock.
  typedef enum {M_IDLE, M_LOAD, M_START, M_WAIT, M_READ} mode_t;
  mode_t       mode;
  int          ld_idx, rd_idx, wait_n;
  bit          exp_ovr, exp_tmo;
  bit          nl_v, nr_v;
  int          nl_addr, nr_idx;
  logic [31:0] nl_data, nr_data;
  int          start_cd, fd_cd;
  int          n_start, n_fd, exp_starts, exp_frames;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply the currently driven inputs to the model for the coming clock edge.
  task automatic commit();
    mode_t m = mode;
    nl_v = 0;
    nr_v = 0;
    if (sample_valid && m != M_LOAD) exp_ovr = 1;
    case (m)
      M_IDLE: if (enable) begin mode = M_LOAD; ld_idx = 0; end
      M_LOAD: if (sample_valid) begin
        nl_v = 1; nl_addr = ld_idx; nl_data = {sample_data, 16'h0000};
        ld_idx++;
        if (ld_idx == N) begin mode = M_START; start_cd = 2; exp_starts++; end
      end
      M_WAIT, M_READ: begin
        if (fft_done) begin
          if (rd_idx < OUT_BINS) begin nr_v = 1; nr_idx = rd_idx; nr_data = fft_data_out; end
          if (rd_idx == OUT_BINS - 1) begin fd_cd = 2; exp_frames++; end
          rd_idx++;
          mode = M_READ;
          if (rd_idx == N) begin mode = enable ? M_LOAD : M_IDLE; ld_idx = 0; end
        end else if (m == M_WAIT) begin
          wait_n++;
          if (wait_n == TMO) begin exp_tmo = 1; mode = M_IDLE; end
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    bit s_exp, f_exp;
    commit();
    @(posedge clk);
    #1;
    s_exp = (start_cd == 1);
    if (start_cd > 0) start_cd--;
    if (s_exp) begin mode = M_WAIT; wait_n = 0; rd_idx = 0; end
    f_exp = (fd_cd == 1);
    if (fd_cd > 0) fd_cd--;
    check("fft_load", fft_load, nl_v);
    if (nl_v) begin
      check("load_addr", fft_load_address, nl_addr);
      check("load_data", fft_data_in, nl_data);
    end
    check("result_valid", result_valid, nr_v);
    if (nr_v) begin
      check("result_idx", result_idx, nr_idx);
      check("result_data", result_data, nr_data);
    end
    check("fft_start", fft_start, s_exp);
    check("frame_done", frame_done, f_exp);
    check("overrun", overrun, exp_ovr);
    check("timeout", timeout, exp_tmo);
    check("busy", busy, mode != M_IDLE);
    check("load_start_excl", fft_load & fft_start, 0);
    n_start += int'(fft_start);
    n_fd    += int'(frame_done);
  endtask

  task automatic do_reset();
    reset = 1; enable = 0; sample_valid = 0; sample_data = 0; fft_done = 0; fft_data_out = 0;
    @(posedge clk);
    #1;
    reset = 0;
    mode = M_IDLE; ld_idx = 0; rd_idx = 0; wait_n = 0; exp_ovr = 0; exp_tmo = 0;
    start_cd = 0; fd_cd = 0; nl_v = 0; nr_v = 0;
    check("rst_fft_load", fft_load, 0);
    check("rst_load_addr", fft_load_address, 0);
    check("rst_load_data", fft_data_in, 0);
    check("rst_fft_start", fft_start, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_result_idx", result_idx, 0);
    check("rst_result_data", result_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout, 0);
    check("rst_busy", busy, 0);
  endtask

  // Feed samples while loading; gap_pct = chance of an idle cycle.
  task automatic load_frame(input bit seq, input int gap_pct, input int drop_at, input int stop_at);
    for (int n = 0; n < 8 * N && mode == M_LOAD && ld_idx != stop_at; n++) begin
      if (ld_idx == drop_at) enable = 0;
      sample_valid = ($urandom_range(99) >= gap_pct);
      sample_data  = seq ? 16'(ld_idx + 1) : 16'($urandom);
      tick();
    end
    sample_valid = 0;
  endtask

  task automatic wait_start();
    for (int n = 0; n < 8 && mode != M_WAIT; n++) tick();
  endtask

  // gap: 0 none, 1 every other cycle, 2 random.
  task automatic read_frame(input bit seq, input int gap);
    bit alt = 0;
    for (int n = 0; n < 8 * N && (mode == M_WAIT || mode == M_READ); n++) begin
      case (gap)
        0:       fft_done = 1;
        1:       begin fft_done = alt; alt = ~alt; end
        default: fft_done = $urandom_range(1);
      endcase
      fft_data_out = seq ? 32'(rd_idx) : $urandom;
      tick();
    end
    fft_done = 0;
    repeat (3) tick();
  endtask

  initial begin
    n_start = 0; n_fd = 0; exp_starts = 0; exp_frames = 0;
    do_reset();

    // Frame 1: samples 0x0001..0x0200 back to back, core returns data = bin index.
    enable = 1;
    tick();
    load_frame(1, 0, -1, -1);
    wait_start();
    read_frame(1, 0);

    // Frame 2: random gaps, enable dropped mid-load, sample during WAIT, gapped bins.
    load_frame(0, 30, 200, -1);
    wait_start();
    sample_valid = 1; sample_data = 16'hdead;
    tick();
    sample_valid = 0;
    read_frame(0, 1);

    // Reset at sample 100, then a full frame must restart at address 0.
    enable = 1;
    tick();
    load_frame(0, 10, -1, 100);
    do_reset();
    enable = 1;
    tick();
    load_frame(0, 20, -1, -1);
    enable = 0;
    wait_start();
    read_frame(1, 2);

    // Timeout: core never answers.
    enable = 1;
    tick();
    load_frame(0, 0, 10, -1);
    wait_start();
    for (int n = 0; n < TMO + 20 && mode == M_WAIT; n++) tick();
    repeat (3) tick();
    check("timeout_final", timeout, 1);
    check("busy_after_timeout", busy, 0);

    check("start_count", n_start, exp_starts);
    check("frame_count", n_fd, exp_frames);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
